// File: rtl/kit_voice_mixer.sv
// Voice mixer: gathers one sample per player each frame, sums them, and
// writes a scaled stereo sample to the codec; merges player clear requests.
module kit_voice_mixer #(
   parameter int NUM_VOICES     = 6,
   parameter int SAMPLE_W       = 10,
   parameter int OUT_W          = 32,
   parameter int COLLECT_CYCLES = 4
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]          voice_valid,
   input  logic [NUM_VOICES-1:0]          voice_clear,
   output logic [NUM_VOICES-1:0]          voice_ready,
   input  logic                           codec_allowed,
   output logic [OUT_W-1:0]               left_channel_audio_out,
   output logic [OUT_W-1:0]               right_channel_audio_out,
   output logic                           write_audio_out,
   output logic                           clear_audio_out_memory
);

   localparam int ACC_W = SAMPLE_W + 3;
   localparam int SHIFT = OUT_W - ACC_W;
   localparam int CNT_W = (COLLECT_CYCLES > 1) ? $clog2(COLLECT_CYCLES) : 1;
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_SUM,
      S_WRITE
   } state_t;

   state_t                               state_q, state_d;
   logic [NUM_VOICES-1:0]                ready_q, ready_d;
   logic [NUM_VOICES-1:0]                cap_q, cap_d;
   logic [NUM_VOICES-1:0][SAMPLE_W-1:0]  smp_q, smp_d;
   logic [ACC_W-1:0]                     acc_q, acc_d;
   logic [CNT_W-1:0]                     cnt_q, cnt_d;
   logic [IDX_W-1:0]                     idx_q, idx_d;
   logic [OUT_W-1:0]                     chan_q, chan_d;
   logic                                 clr_q, clr_d;
   logic                                 wr;

   always_comb begin
      state_d = state_q;
      ready_d = ready_q;
      cap_d   = cap_q;
      smp_d   = smp_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      chan_d  = chan_q;
      clr_d   = |voice_clear;
      wr      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (codec_allowed) begin
               state_d = S_COLLECT;
               cap_d   = '0;
               smp_d   = '0;
               ready_d = '1;
               cnt_d   = CNT_W'(COLLECT_CYCLES - 1);
            end
         end
         S_COLLECT: begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (voice_valid[i] && ready_q[i]) begin
                  smp_d[i] = voice_sample[i*SAMPLE_W +: SAMPLE_W];
                  cap_d[i] = 1'b1;
               end
            end
            ready_d = ~cap_d;
            if (cnt_q == '0) begin
               state_d = S_SUM;
               ready_d = '0;
               acc_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SUM: begin
            // uncaptured latches were zeroed at frame start, so they add 0
            acc_d = acc_q + ACC_W'($signed(smp_q[idx_q]));
            if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
               state_d = S_WRITE;
               chan_d  = OUT_W'($signed(acc_d)) << SHIFT;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_WRITE: begin
            if (codec_allowed) begin
               wr      = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // a clear request kills the frame, including a pending write
      if (|voice_clear) begin
         state_d = S_IDLE;
         cap_d   = '0;
         ready_d = '0;
         chan_d  = chan_q;
         wr      = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         state_q <= S_IDLE;
         ready_q <= '0;
         cap_q   <= '0;
         smp_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         chan_q  <= '0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         cap_q   <= cap_d;
         smp_q   <= smp_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         chan_q  <= chan_d;
         clr_q   <= clr_d;
      end
   end

   assign voice_ready             = ready_q;
   assign left_channel_audio_out  = chan_q;
   assign right_channel_audio_out = chan_q;
   assign write_audio_out         = wr;
   assign clear_audio_out_memory  = clr_q;

endmodule

// File: doc/kit_voice_mixer.md
Name: kit_voice_mixer

Overview:
- Sits directly downstream of the per-key sound players.
- Collects one signed 10-bit sample per frame from each of NUM_VOICES players, handshaking with each player's write_audio_out/audio_out_allowed pair.
- Sums the collected samples sequentially and scales the sum to codec width.
- Writes one stereo sample per frame to the audio controller FIFOs.
- Merges the players' clear_buffer requests into a single codec-memory clear.

Parameters:
NUM_VOICES, 6, number of sound players mixed (1..8)
SAMPLE_W, 10, player sample width, signed two's complement
OUT_W, 32, codec sample width per channel
COLLECT_CYCLES, 4, length of the sample-collection window per frame (>=1)

Ports:
clock  in  1  system clock
resetn  in  1  reset; asynchronous, active-high (1 = reset) despite the name
voice_sample  in  NUM_VOICES*SAMPLE_W  packed player audio_out; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W]
voice_valid  in  NUM_VOICES  player write_audio_out strobes
voice_clear  in  NUM_VOICES  player clear_buffer requests
voice_ready  out  NUM_VOICES  drives each player's audio_out_allowed
codec_allowed  in  1  audio controller has space in both left and right FIFOs
left_channel_audio_out  out  OUT_W  mixed sample, left channel
right_channel_audio_out  out  OUT_W  mixed sample, right channel (equals left)
write_audio_out  out  1  one-cycle codec write strobe
clear_audio_out_memory  out  1  codec FIFO clear

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; all outputs 0; captured mask 0; sample latches 0; accumulator 0; counters 0.
- ACC_W = SAMPLE_W+3 (13 at default). Samples are sign-extended to ACC_W; no overflow is possible for NUM_VOICES<=8.
- Output scaling: output = accumulator sign-extended to OUT_W, then shifted left by OUT_W-ACC_W (19 at default).
- IDLE: outputs quiet. If codec_allowed=1, clear the captured mask, zero the sample latches, load the collection counter, and go to COLLECT.
- COLLECT, COLLECT_CYCLES cycles:
  - voice_ready[i] = ~captured[i] (registered output).
  - voice_valid[i] & voice_ready[i] in the same cycle latches sample i and sets captured[i].
  - voice_valid while voice_ready=0 is ignored.
  - After COLLECT_CYCLES cycles, go to SUM; voice_ready drops to 0 on the SUM entry edge.
- SUM, NUM_VOICES cycles: accumulator cleared on entry, then adds one latched sample per cycle, index 0 first. Voices not captured contribute 0.
- WRITE:
  - Both channel outputs are loaded with the scaled accumulator.
  - write_audio_out=1 for exactly one cycle, in a cycle where codec_allowed=1; hold in WRITE while codec_allowed=0.
  - Then return to IDLE.
  - Channel outputs hold their value until the next WRITE.
- Latency: with codec_allowed held at 1, write_audio_out asserts COLLECT_CYCLES+NUM_VOICES+1 cycles after the IDLE cycle that sampled codec_allowed=1.
- Clear:
  - Any voice_clear bit high makes clear_audio_out_memory=1 on the next cycle (registered OR, one cycle per asserted cycle).
  - It also aborts the current frame: go to IDLE, drop the captured mask, no write.
  - Clear takes priority over a same-cycle write: the write is suppressed.
- Simultaneous voice_valid from several voices: all are latched in the same cycle.
- Reset asserted mid-frame: immediate return to reset values; no partial write is ever issued.

Test Plan:
- Voices 0,1,2 deliver 100, 200, -50 during COLLECT; others silent; codec_allowed=1 -> a single write_audio_out pulse at cycle 11 after IDLE; both channels 0x07D00000.
- All six voices deliver 511 -> channels 0x5FD00000. All six deliver -512 -> channels 0xA0000000.
- codec_allowed=0 when WRITE is entered, raised 5 cycles later -> write pulses in the first cycle codec_allowed=1; sample value unchanged.
- Voice 3 asserts voice_valid on two consecutive COLLECT cycles with values 40 then 70 -> only 40 captured; voice_ready[3] is 0 in the second cycle.
- voice_clear[4]=1 during SUM -> clear_audio_out_memory=1 on the next cycle; no write that frame; next frame proceeds normally.
- resetn=1 asserted during COLLECT -> all outputs 0 immediately; after release, the first write carries only the new frame's samples.
